// File: rtl/ledpanel_pkg.sv
// Shared constants and types for the LED panel write path.
package ledpanel_pkg;

  localparam int PANEL_WIDTH  = 96;
  localparam int PANEL_HEIGHT = 48;
  localparam int PIXELS       = PANEL_WIDTH * PANEL_HEIGHT;

  localparam int EN_W   = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [EN_W-1:0]   panel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/ledpanel_watchdog.sv
// Counts cycles since the last network beat; raises lost_o once the count reaches TIMEOUT.
module ledpanel_watchdog #(
  parameter logic [23:0] TIMEOUT = 24'd12_500_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic beat_i,
  output logic lost_o
);

  logic [23:0] cnt_q, cnt_d;
  logic        lost_q, lost_d;

  always_comb begin
    cnt_d  = cnt_q;
    lost_d = lost_q;
    if (beat_i) begin
      cnt_d  = '0;
      lost_d = 1'b0;
    end else begin
      if (cnt_q != TIMEOUT) cnt_d = cnt_q + 24'd1;
      if (cnt_d == TIMEOUT) lost_d = 1'b1;
    end
  end

  // Flag starts set so panels show no-signal until the network delivers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      lost_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      lost_q <= lost_d;
    end
  end

  assign lost_o = lost_q;

endmodule

// File: rtl/ledpanel_write_arbiter.sv
// Round-robin burst arbiter sharing the panel write bus between the network and local sources.
module ledpanel_write_arbiter
  import ledpanel_pkg::*;
#(
  parameter int          NUM_PANELS   = 8,
  parameter int          PIXELS       = ledpanel_pkg::PIXELS,
  parameter int          MAX_BURST    = 256,
  parameter int          IDLE_RELEASE = 16,
  parameter logic [23:0] TIMEOUT      = 24'd12_500_000
) (
  input  logic              display_clock,
  input  logic              display_rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [EN_W-1:0]   s0_panel,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [EN_W-1:0]   s1_panel,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic [EN_W-1:0]   ctrl_en,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wdat,
  output logic [1:0]        grant,
  output logic              signal_lost,
  output logic [15:0]       drop_count
);

  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int ICW = $clog2(IDLE_RELEASE + 1);

  arb_state_e        state_q, state_d;
  logic              last_owner_q, last_owner_d;  // 0 = s0, 1 = s1
  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ICW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [1:0]        ready_q, ready_d;
  logic [EN_W-1:0]   en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [15:0]       drop_q, drop_d;

  logic  acc0, acc1, acc, legal, rel;
  beat_t sel;

  assign acc0 = s0_valid & ready_q[0];
  assign acc1 = s1_valid & ready_q[1];
  assign acc  = acc0 | acc1;

  always_comb begin
    sel.panel = s0_panel;
    sel.addr  = s0_addr;
    sel.data  = s0_data;
    sel.last  = s0_last;
    if (acc1) begin
      sel.panel = s1_panel;
      sel.addr  = s1_addr;
      sel.data  = s1_data;
      sel.last  = s1_last;
    end
  end

  assign legal = (sel.panel != '0) &&
                 (32'(sel.panel) <= 32'(NUM_PANELS)) &&
                 (32'(sel.addr) < 32'(PIXELS));

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    rel          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        beat_cnt_d = '0;
        idle_cnt_d = '0;
        if (s0_valid && s1_valid) state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        else if (s0_valid)        state_d = ST_OWN0;
        else if (s1_valid)        state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (acc) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
          idle_cnt_d = '0;
          rel        = sel.last || (beat_cnt_q == BCW'(MAX_BURST - 1));
        end else begin
          idle_cnt_d = idle_cnt_q + ICW'(1);
          rel        = (idle_cnt_q == ICW'(IDLE_RELEASE - 1));
        end
        if (rel) begin
          state_d      = ST_IDLE;
          last_owner_d = (state_q == ST_OWN1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready follows the next state so it drops on the same edge the grant ends.
    ready_d = {state_d == ST_OWN1, state_d == ST_OWN0};
  end

  always_comb begin
    en_d   = '0;
    addr_d = addr_q;
    wdat_d = wdat_q;
    drop_d = drop_q;
    if (acc) begin
      addr_d = sel.addr;
      wdat_d = sel.data;
      if (legal)              en_d   = sel.panel;
      else if (drop_q != '1)  drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge display_clock or negedge display_rst_n) begin
    if (!display_rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      ready_q      <= '0;
      en_q         <= '0;
      addr_q       <= '0;
      wdat_q       <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      ready_q      <= ready_d;
      en_q         <= en_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      drop_q       <= drop_d;
    end
  end

  ledpanel_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i (display_clock),
    .rst_ni(display_rst_n),
    .beat_i(acc0),
    .lost_o(signal_lost)
  );

  assign grant      = {state_q == ST_OWN1, state_q == ST_OWN0};
  assign s0_ready   = ready_q[0];
  assign s1_ready   = ready_q[1];
  assign ctrl_en    = en_q;
  assign ctrl_addr  = addr_q;
  assign ctrl_wdat  = wdat_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_ledpanel_write_arbiter.sv
// Randomized bench for ledpanel_write_arbiter against a cycle-level policy model.
module tb_ledpanel_write_arbiter;

  localparam int MAXB  = 8;
  localparam int IDLER = 16;
  localparam int TO    = 100;
  localparam int NP    = 8;
  localparam int PIX   = 4608;

  typedef struct {
    logic [7:0]  panel;
    logic [15:0] addr;
    logic [23:0] data;
    bit          last;
  } bt;

  logic        display_clock = 1'b0;
  logic        display_rst_n = 1'b0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [7:0]  s0_panel = '0, s1_panel = '0;
  logic [15:0] s0_addr = '0, s1_addr = '0;
  logic [23:0] s0_data = '0, s1_data = '0;
  logic        s0_last = 1'b0, s1_last = 1'b0;
  logic [7:0]  ctrl_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic [1:0]  grant;
  logic        signal_lost;
  logic [15:0] drop_count;

  ledpanel_write_arbiter #(
    .NUM_PANELS  (NP),
    .PIXELS      (PIX),
    .MAX_BURST   (MAXB),
    .IDLE_RELEASE(IDLER),
    .TIMEOUT     (24'(TO))
  ) dut (
    .display_clock(display_clock), .display_rst_n(display_rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_panel(s0_panel),
    .s0_addr(s0_addr), .s0_data(s0_data), .s0_last(s0_last),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_panel(s1_panel),
    .s1_addr(s1_addr), .s1_data(s1_data), .s1_last(s1_last),
    .ctrl_en(ctrl_en), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
    .grant(grant), .signal_lost(signal_lost), .drop_count(drop_count)
  );

  always #5 display_clock = ~display_clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source queues and pacing
  bt  q0[$], q1[$];
  int gap0 = 0, gap1 = 0, pause0 = 0, pause1 = 0;
  bit rnd_pause = 0;

  // Policy model: owner 0 = nobody, 1 = s0, 2 = s1
  int          m_owner, m_last, m_beats, m_idle, m_wd, m_drops, m_acc0, en_seen;
  logic [7:0]  m_en;
  logic [15:0] m_addr;
  logic [23:0] m_dat;
  bit          m_lost;

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_beats = 0; m_idle = 0;
    m_wd = 0; m_lost = 1; m_drops = 0;
    m_en = '0; m_addr = '0; m_dat = '0;
  endtask

  task automatic model_edge();
    bit a0, a1, rel;
    bt  b;
    a0 = (m_owner == 1) && s0_valid;
    a1 = (m_owner == 2) && s1_valid;
    b  = '{default: 0};
    m_en = '0;
    if (a0) begin b = q0.pop_front(); m_acc0++; end
    if (a1) b = q1.pop_front();
    if (a0 || a1) begin
      m_addr = b.addr;
      m_dat  = b.data;
      if (b.panel >= 1 && b.panel <= NP && b.addr < PIX) m_en = b.panel;
      else if (m_drops < 65535) m_drops++;
    end
    if (a0) begin m_wd = 0; m_lost = 0; end
    else begin
      if (m_wd < TO) m_wd++;
      if (m_wd == TO) m_lost = 1;
    end
    if (m_owner == 0) begin
      if (s0_valid && s1_valid) m_owner = (m_last == 1) ? 2 : 1;
      else if (s0_valid) m_owner = 1;
      else if (s1_valid) m_owner = 2;
      m_beats = 0; m_idle = 0;
    end else begin
      if (a0 || a1) begin
        m_beats++; m_idle = 0;
        rel = b.last || (m_beats == MAXB);
      end else begin
        m_idle++;
        rel = (m_idle == IDLER);
      end
      if (rel) begin m_last = m_owner; m_owner = 0; end
    end
  endtask

  task automatic check_outputs();
    logic [1:0] eg;
    eg = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    check("grant",     32'(grant),       32'(eg));
    check("s0_ready",  32'(s0_ready),    32'(m_owner == 1));
    check("s1_ready",  32'(s1_ready),    32'(m_owner == 2));
    check("ctrl_en",   32'(ctrl_en),     32'(m_en));
    check("ctrl_addr", 32'(ctrl_addr),   32'(m_addr));
    check("ctrl_wdat", 32'(ctrl_wdat),   32'(m_dat));
    check("lost",      32'(signal_lost), 32'(m_lost));
    check("drops",     32'(drop_count),  32'(m_drops));
    if (ctrl_en != '0) en_seen++;
  endtask

  function automatic bt rnd_beat(bit last);
    bt b;
    b.panel = 8'($urandom_range(0, 9));
    b.addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(4600, 4700))
                                          : 16'($urandom_range(0, PIX - 1));
    b.data  = 24'($urandom);
    b.last  = last;
    return b;
  endfunction

  function automatic bt legal_beat(logic [7:0] p, logic [15:0] a, bit last);
    bt b;
    b.panel = p; b.addr = a; b.data = 24'($urandom); b.last = last;
    return b;
  endfunction

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic cyc();
    bit v0, v1;
    if (rnd_pause) begin
      if (pause0 > 0) pause0--; else if ($urandom_range(0, 39) == 0) pause0 = $urandom_range(4, 24);
      if (pause1 > 0) pause1--; else if ($urandom_range(0, 39) == 0) pause1 = $urandom_range(4, 24);
    end
    v0 = (q0.size() > 0) && (pause0 == 0) && ($urandom_range(0, 99) >= gap0);
    v1 = (q1.size() > 0) && (pause1 == 0) && ($urandom_range(0, 99) >= gap1);
    s0_valid = v0;
    s1_valid = v1;
    if (q0.size() > 0) begin
      s0_panel = q0[0].panel; s0_addr = q0[0].addr; s0_data = q0[0].data; s0_last = q0[0].last;
    end else begin
      s0_panel = 8'($urandom); s0_addr = 16'($urandom); s0_data = 24'($urandom); s0_last = 1'($urandom);
    end
    if (q1.size() > 0) begin
      s1_panel = q1[0].panel; s1_addr = q1[0].addr; s1_data = q1[0].data; s1_last = q1[0].last;
    end else begin
      s1_panel = 8'($urandom); s1_addr = 16'($urandom); s1_data = 24'($urandom); s1_last = 1'($urandom);
    end
    @(posedge display_clock);
    model_edge();
    @(negedge display_clock);
    check_outputs();
  endtask

  task automatic drain(input int extra);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < 400) begin cyc(); k++; end
    check("drain_bound", 32'(q0.size() + q1.size()), 32'd0);
    repeat (extra) cyc();
  endtask

  task automatic apply_reset();
    display_rst_n = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
    q0.delete(); q1.delete();
    pause0 = 0; pause1 = 0;
    model_reset();
    repeat (2) @(negedge display_clock);
    check_outputs();
    display_rst_n = 1'b1;
  endtask

  initial begin
    int base, k;
    model_reset();
    m_acc0 = 0; en_seen = 0;
    apply_reset();

    // 1: s0 alone, four beats to panel 1
    en_seen = 0;
    for (int i = 0; i < 4; i++) q0.push_back(legal_beat(8'd1, 16'(i), i == 3));
    repeat (10) cyc();
    check("t1_writes", 32'(en_seen), 32'd4);
    check("t1_lost", 32'(signal_lost), 32'd0);

    // 2: both continuously valid, 3-beat bursts
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 3; i++) begin
        q0.push_back(legal_beat(8'(1 + b), 16'(10 * b + i), i == 2));
        q1.push_back(legal_beat(8'(4 + b), 16'(200 + i), i == 2));
      end
    drain(4);

    // 3: s1 never asserts last, forced release after MAX_BURST beats
    for (int i = 0; i < 12; i++) q1.push_back(legal_beat(8'd5, 16'(300 + i), 1'b0));
    cyc(); cyc(); cyc();
    q0.push_back(legal_beat(8'd2, 16'd50, 1'b0));
    q0.push_back(legal_beat(8'd2, 16'd51, 1'b1));
    drain(20);

    // 4: illegal panel/address beats among legal neighbours
    q0.push_back(legal_beat(8'd1, 16'd10, 1'b0));
    q0.push_back(legal_beat(8'd0, 16'd11, 1'b0));
    q0.push_back(legal_beat(8'd9, 16'd12, 1'b0));
    q0.push_back(legal_beat(8'd2, 16'd4608, 1'b0));
    q0.push_back(legal_beat(8'd8, 16'd4607, 1'b1));
    drain(2);
    check("t4_drops", 32'(drop_count), 32'd3);

    // 5: s0 silent past TIMEOUT while s1 keeps the bus busy
    for (int i = 0; i < 14; i++)
      for (int j = 0; j < 6; j++) q1.push_back(legal_beat(8'd3, 16'(j), j == 5));
    gap1 = 20;
    drain(30);
    gap1 = 0;
    check("t5_lost_set", 32'(signal_lost), 32'd1);
    q0.push_back(legal_beat(8'd1, 16'd7, 1'b1));
    drain(3);
    check("t5_lost_clr", 32'(signal_lost), 32'd0);

    // 6: reset mid-burst after the second beat
    for (int i = 0; i < 5; i++) q0.push_back(legal_beat(8'd3, 16'(100 + i), i == 4));
    base = m_acc0;
    k = 0;
    while (m_acc0 < base + 2 && k < 30) begin cyc(); k++; end
    check("t6_wait", 32'(m_acc0 - base), 32'd2);
    #2;
    display_rst_n = 1'b0;
    #1;
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_ready", 32'({s1_ready, s0_ready}), 32'd0);
    check("t6_en", 32'(ctrl_en), 32'd0);
    apply_reset();
    repeat (8) cyc();
    check("t6_drops", 32'(drop_count), 32'd0);

    // 7: randomized mixed traffic
    rnd_pause = 1;
    gap0 = 10; gap1 = 10;
    for (int c = 0; c < 3000; c++) begin
      if (q0.size() < 2 && $urandom_range(0, 7) == 0) begin
        int n; bit l;
        n = $urandom_range(1, 12); l = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < n; i++) q0.push_back(rnd_beat(l && (i == n - 1)));
      end
      if (q1.size() < 2 && $urandom_range(0, 7) == 0) begin
        int n; bit l;
        n = $urandom_range(1, 12); l = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < n; i++) q1.push_back(rnd_beat(l && (i == n - 1)));
      end
      cyc();
    end
    rnd_pause = 0; pause0 = 0; pause1 = 0;
    drain(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ledpanel_write_arbiter.md
Name: ledpanel_write_arbiter

Overview:
Shares the single panel write bus (ctrl_en / ctrl_addr / ctrl_wdat) between two pixel sources:
- s0: network frame receiver.
- s1: local pattern/"no signal" generator.

Grants the bus per burst, round-robin, with forced release and idle timeout. Range-checks every beat and drops illegal ones. Runs a watchdog on s0 that flags loss of network video. Sits between the sources and the chain of ledpanel instances, all on display_clock.

Parameters:
NUM_PANELS, 8, highest valid panel index; legal panel indices are 1..NUM_PANELS.
PIXELS, 4608, pixels per panel (96x48); legal addr 0..PIXELS-1.
MAX_BURST, 256, beats before the owner is forcibly released.
IDLE_RELEASE, 16, consecutive owner-idle cycles before release.
TIMEOUT, 24'd12_500_000, s0-silent cycles before signal_lost is set.

Ports:
display_clock  in  1  single clock for block and panel bus.
display_rst_n  in  1  asynchronous, active-low reset.
s0_valid  in  1  source 0 beat valid.
s0_ready  out  1  source 0 beat accepted when valid&ready.
s0_panel  in  8  target panel index.
s0_addr  in  16  pixel address (row*96+col).
s0_data  in  24  RGB888 pixel.
s0_last  in  1  final beat of burst.
s1_valid, s1_ready, s1_panel, s1_addr, s1_data, s1_last  same widths and meaning for source 1.
ctrl_en  out  8  panel select for the write; 0 = no write.
ctrl_addr  out  16  write address.
ctrl_wdat  out  24  write data.
grant  out  2  one-hot current owner; 00 = idle.
signal_lost  out  1  s0 silent for at least TIMEOUT cycles.
drop_count  out  16  saturating count of rejected beats.

Behaviour:
- Reset (async assert, sync release) drives:
  - FSM to IDLE, grant=00.
  - s0_ready=s1_ready=0.
  - ctrl_en=0, ctrl_addr=0, ctrl_wdat=0.
  - drop_count=0.
  - signal_lost=1 (panels show no-signal until s0 delivers).
  - Watchdog counter=0, last_owner=1 (so s0 wins the first tie).
- Reset asserted mid-burst aborts the burst; no partial write is emitted after reset.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: if s0_valid & s1_valid, go to the owner != last_owner. Else go to whichever is valid. Else stay.
  - OWNx -> IDLE on any of:
    - an accepted beat with last=1;
    - beat counter reaches MAX_BURST (forced release, even without last);
    - idle counter reaches IDLE_RELEASE.
  - On leaving OWNx: last_owner := x.
  - Exactly one IDLE cycle separates consecutive grants.
- Ready rules:
  - sx_ready is registered.
  - sx_ready=1 only while in OWNx, and is cleared in the same cycle the FSM leaves OWNx.
  - The non-owner's ready is always 0.
  - No backpressure from the panel bus; the owner may stream one beat per cycle.
- Counters:
  - Beat counter: clears on grant, increments per accepted beat.
  - Idle counter: clears on an accepted beat, increments on owner cycles without valid.
- Output path (latency 1):
  - On an accepted beat, the next cycle drives ctrl_addr=addr and ctrl_wdat=data.
  - ctrl_en=panel if the beat is legal, else ctrl_en=0.
  - Legal beat: 1<=panel<=NUM_PANELS and addr<PIXELS.
  - In every cycle without an accepted beat, ctrl_en=0 and ctrl_addr/ctrl_wdat hold.
- drop_count: +1 per illegal accepted beat; saturates at 16'hFFFF. Illegal beats still count toward the burst, and last still releases.
- Watchdog:
  - Counts cycles since the last accepted s0 beat, saturating at TIMEOUT.
  - signal_lost=1 when the count == TIMEOUT.
  - An accepted s0 beat (legal or not) clears both the count and signal_lost on the next edge.
  - s1 activity does not affect the watchdog.
- Simultaneous events:
  - last on the MAX_BURST-th beat counts as a single release.
  - The beat that triggers release is forwarded normally.

Decomposition:
- Shared package ledpanel_pkg:
  - PANEL_WIDTH=96, PANEL_HEIGHT=48, PIXELS.
  - Bus widths: EN_W=8, ADDR_W=16, DATA_W=24.
  - FSM state typedef.
- One natural sub-module: ledpanel_watchdog (saturating counter plus flag, parameter TIMEOUT). Instantiate with a small TIMEOUT in the bench.

Test Plan:
1. Reset release with only s0 streaming 4 beats, panel=1, addr 0..3, last on beat 4 → grant=01 one cycle after valid. ctrl_en=1 for 4 consecutive cycles, one cycle after each accept. Then grant=00, signal_lost falls.
2. Both sources valid continuously, 3-beat bursts → grants alternate 01,00,10,00,01… First grant goes to s0; the non-owner's ready never rises.
3. s1 streams with last never asserted, MAX_BURST=8 → release after exactly 8 accepted beats. s0 is granted next if valid.
4. Beats with panel=0, panel=NUM_PANELS+1, and addr=4608 → ctrl_en=0 for each, drop_count=3. Legal neighbouring beats are written normally.
5. TIMEOUT=100, s0 silent 100 cycles → signal_lost=1 at cycle 100. One s0 beat clears it. s1-only traffic keeps it set.
6. Assert display_rst_n low mid-burst (beat 2 of 5) → ready, grant and ctrl_en go 0 immediately (asynchronously). After release, no stale write appears and drop_count=0.
